// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating stall counter.
// Latency: 1 cycle from _id inputs to _ex outputs; Stall is combinational (0 cycles).
// Backpressure: Stall freezes the PC and IF/ID upstream while this stage loads a bubble; Flush_ex overrides Stall.
// Optional feature: define ID_EX_WB_BYPASS_EN to forward the write-back result into rs1Data_ex/rs2Data_ex on capture.
module id_ex_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             ALUCode_id,
  input  logic                   ALUSrcA_id,
  input  logic [1:0]             ALUSrcB_id,
  input  logic                   RegWrite_id,
  input  logic                   MemRead_id,
  input  logic                   MemWrite_id,
  input  logic                   MemtoReg_id,
  input  logic [31:0]            Imm_id,
  input  logic [31:0]            PC_id,
  input  logic [31:0]            rs1Data_id,
  input  logic [31:0]            rs2Data_id,
  input  logic [4:0]             rs1Addr_id,
  input  logic [4:0]             rs2Addr_id,
  input  logic [4:0]             rdAddr_id,
  input  logic                   Flush_ex,
  input  logic                   RegWrite_wb,
  input  logic [4:0]             rdAddr_wb,
  input  logic [31:0]            RegWriteData_wb,
  output logic [3:0]             ALUCode_ex,
  output logic                   ALUSrcA_ex,
  output logic [1:0]             ALUSrcB_ex,
  output logic                   RegWrite_ex,
  output logic                   MemRead_ex,
  output logic                   MemWrite_ex,
  output logic                   MemtoReg_ex,
  output logic [31:0]            Imm_ex,
  output logic [31:0]            PC_ex,
  output logic [31:0]            rs1Data_ex,
  output logic [31:0]            rs2Data_ex,
  output logic [4:0]             rs1Addr_ex,
  output logic [4:0]             rs2Addr_ex,
  output logic [4:0]             rdAddr_ex,
  output logic                   Stall,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic        hazard;
  logic        bubble;
  logic [31:0] rs1_next;
  logic [31:0] rs2_next;

  // A load in EX whose destination is a source of the ID instruction; x0 is never a real dependency.
  assign hazard = MemRead_ex && (rdAddr_ex != 5'd0) &&
                  ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));

  // A flush squashes the ID instruction anyway, so there is nothing to hold upstream.
  assign Stall  = hazard && !Flush_ex;
  assign bubble = Flush_ex || hazard;

`ifdef ID_EX_WB_BYPASS_EN
  // Forward a same-cycle register-file write so EX never sees the stale read value.
  always_comb begin
    rs1_next = rs1Data_id;
    rs2_next = rs2Data_id;
    if (RegWrite_wb && (rdAddr_wb != 5'd0) && (rdAddr_wb == rs1Addr_id)) rs1_next = RegWriteData_wb;
    if (RegWrite_wb && (rdAddr_wb != 5'd0) && (rdAddr_wb == rs2Addr_id)) rs2_next = RegWriteData_wb;
  end
`else
  assign rs1_next = rs1Data_id;
  assign rs2_next = rs2Data_id;

  // Write-back port only matters for the bypass build.
  logic unused_wb;
  assign unused_wb = &{1'b0, RegWrite_wb, rdAddr_wb, RegWriteData_wb};
`endif

  // Pipeline register: capture ID, or load a bubble that keeps the PC for trace/debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUCode_ex  <= '0;
      ALUSrcA_ex  <= 1'b0;
      ALUSrcB_ex  <= '0;
      RegWrite_ex <= 1'b0;
      MemRead_ex  <= 1'b0;
      MemWrite_ex <= 1'b0;
      MemtoReg_ex <= 1'b0;
      Imm_ex      <= '0;
      PC_ex       <= '0;
      rs1Data_ex  <= '0;
      rs2Data_ex  <= '0;
      rs1Addr_ex  <= '0;
      rs2Addr_ex  <= '0;
      rdAddr_ex   <= '0;
    end else if (bubble) begin
      ALUCode_ex  <= '0;
      ALUSrcA_ex  <= 1'b0;
      ALUSrcB_ex  <= '0;
      RegWrite_ex <= 1'b0;
      MemRead_ex  <= 1'b0;
      MemWrite_ex <= 1'b0;
      MemtoReg_ex <= 1'b0;
      Imm_ex      <= '0;
      PC_ex       <= PC_id;
      rs1Data_ex  <= '0;
      rs2Data_ex  <= '0;
      rs1Addr_ex  <= '0;
      rs2Addr_ex  <= '0;
      rdAddr_ex   <= '0;
    end else begin
      ALUCode_ex  <= ALUCode_id;
      ALUSrcA_ex  <= ALUSrcA_id;
      ALUSrcB_ex  <= ALUSrcB_id;
      RegWrite_ex <= RegWrite_id;
      MemRead_ex  <= MemRead_id;
      MemWrite_ex <= MemWrite_id;
      MemtoReg_ex <= MemtoReg_id;
      Imm_ex      <= Imm_id;
      PC_ex       <= PC_id;
      rs1Data_ex  <= rs1_next;
      rs2Data_ex  <= rs2_next;
      rs1Addr_ex  <= rs1Addr_id;
      rs2Addr_ex  <= rs2Addr_id;
      rdAddr_ex   <= rdAddr_id;
    end
  end

  // Count inserted load-use bubbles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != {STALL_CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each EX-stage snapshot, a monitor compares after every edge.
// Directed load-use, x0, flush, bypass, saturation and reset scenarios, then randomized traffic.
// Built with a 4-bit stall counter so saturation is reachable.
module tb_id_ex_stage;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0]  alu;
    logic        srca;
    logic [1:0]  srcb;
    logic        rw, mr, mw, m2r;
    logic [31:0] imm, pc, d1, d2;
    logic [4:0]  a1, a2, rd;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] ALUCode_id;
  logic ALUSrcA_id;
  logic [1:0] ALUSrcB_id;
  logic RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id;
  logic [31:0] Imm_id, PC_id, rs1Data_id, rs2Data_id;
  logic [4:0] rs1Addr_id, rs2Addr_id, rdAddr_id;
  logic Flush_ex, RegWrite_wb;
  logic [4:0] rdAddr_wb;
  logic [31:0] RegWriteData_wb;
  logic [3:0] ALUCode_ex;
  logic ALUSrcA_ex;
  logic [1:0] ALUSrcB_ex;
  logic RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex;
  logic [4:0] rs1Addr_ex, rs2Addr_ex, rdAddr_ex;
  logic Stall;
  logic [W-1:0] StallCount;

  id_ex_stage #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUCode_id(ALUCode_id), .ALUSrcA_id(ALUSrcA_id), .ALUSrcB_id(ALUSrcB_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id), .MemtoReg_id(MemtoReg_id),
    .Imm_id(Imm_id), .PC_id(PC_id), .rs1Data_id(rs1Data_id), .rs2Data_id(rs2Data_id),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .rdAddr_id(rdAddr_id),
    .Flush_ex(Flush_ex), .RegWrite_wb(RegWrite_wb), .rdAddr_wb(rdAddr_wb), .RegWriteData_wb(RegWriteData_wb),
    .ALUCode_ex(ALUCode_ex), .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
    .Imm_ex(Imm_ex), .PC_ex(PC_ex), .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex),
    .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rdAddr_ex(rdAddr_ex),
    .Stall(Stall), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  ex_t model;          // what the EX register should hold right now
  int  model_cnt;      // what StallCount should hold right now
  ex_t exp_q[$];
  int  cnt_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest prediction.
  ex_t e;
  int  ec;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ec = cnt_q.pop_front();
      check("ALUCode_ex", 64'(ALUCode_ex), 64'(e.alu));
      check("ALUSrcA_ex", 64'(ALUSrcA_ex), 64'(e.srca));
      check("ALUSrcB_ex", 64'(ALUSrcB_ex), 64'(e.srcb));
      check("RegWrite_ex", 64'(RegWrite_ex), 64'(e.rw));
      check("MemRead_ex", 64'(MemRead_ex), 64'(e.mr));
      check("MemWrite_ex", 64'(MemWrite_ex), 64'(e.mw));
      check("MemtoReg_ex", 64'(MemtoReg_ex), 64'(e.m2r));
      check("Imm_ex", 64'(Imm_ex), 64'(e.imm));
      check("PC_ex", 64'(PC_ex), 64'(e.pc));
      check("rs1Data_ex", 64'(rs1Data_ex), 64'(e.d1));
      check("rs2Data_ex", 64'(rs2Data_ex), 64'(e.d2));
      check("rs1Addr_ex", 64'(rs1Addr_ex), 64'(e.a1));
      check("rs2Addr_ex", 64'(rs2Addr_ex), 64'(e.a2));
      check("rdAddr_ex", 64'(rdAddr_ex), 64'(e.rd));
      check("StallCount", 64'(StallCount), 64'(ec));
    end
  end

  // Reference: a load in EX blocks any ID reader of its (nonzero) destination; flush wins; bubbles keep only PC.
  task automatic predict_edge();
    logic hz, stall_exp;
    ex_t nxt;
    #1;
    hz = model.mr && (model.rd != 0) && (model.rd == rs1Addr_id || model.rd == rs2Addr_id);
    stall_exp = hz && !Flush_ex;
    check("Stall", 64'(Stall), 64'(stall_exp));
    if (Flush_ex || hz) begin
      nxt = '0;
      nxt.pc = PC_id;
    end else begin
      nxt = '{alu: ALUCode_id, srca: ALUSrcA_id, srcb: ALUSrcB_id, rw: RegWrite_id, mr: MemRead_id,
              mw: MemWrite_id, m2r: MemtoReg_id, imm: Imm_id, pc: PC_id, d1: rs1Data_id, d2: rs2Data_id,
              a1: rs1Addr_id, a2: rs2Addr_id, rd: rdAddr_id};
`ifdef ID_EX_WB_BYPASS_EN
      if (RegWrite_wb && rdAddr_wb != 0 && rdAddr_wb == rs1Addr_id) nxt.d1 = RegWriteData_wb;
      if (RegWrite_wb && rdAddr_wb != 0 && rdAddr_wb == rs2Addr_id) nxt.d2 = RegWriteData_wb;
`endif
    end
    if (stall_exp && model_cnt < (1 << W) - 1) model_cnt++;
    model = nxt;
    exp_q.push_back(nxt);
    cnt_q.push_back(model_cnt);
  endtask

  task automatic set_idle();
    ALUCode_id = 0; ALUSrcA_id = 0; ALUSrcB_id = 0;
    RegWrite_id = 0; MemRead_id = 0; MemWrite_id = 0; MemtoReg_id = 0;
    Imm_id = 0; PC_id = 0; rs1Data_id = 0; rs2Data_id = 0;
    rs1Addr_id = 0; rs2Addr_id = 0; rdAddr_id = 0;
    Flush_ex = 0; RegWrite_wb = 0; rdAddr_wb = 0; RegWriteData_wb = 0;
  endtask

  task automatic set_random();
    ALUCode_id = 4'($urandom); ALUSrcA_id = 1'($urandom); ALUSrcB_id = 2'($urandom);
    RegWrite_id = 1'($urandom); MemRead_id = 1'($urandom); MemWrite_id = 1'($urandom);
    MemtoReg_id = 1'($urandom);
    Imm_id = $urandom; PC_id = $urandom; rs1Data_id = $urandom; rs2Data_id = $urandom;
    rs1Addr_id = 5'($urandom_range(0, 7)); rs2Addr_id = 5'($urandom_range(0, 7));
    rdAddr_id = 5'($urandom_range(0, 7));
    Flush_ex = ($urandom_range(0, 99) < 15);
    RegWrite_wb = 1'($urandom); rdAddr_wb = 5'($urandom_range(0, 7)); RegWriteData_wb = $urandom;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " RegWrite_ex"}, 64'(RegWrite_ex), 0);
    check({tag, " MemRead_ex"}, 64'(MemRead_ex), 0);
    check({tag, " MemWrite_ex"}, 64'(MemWrite_ex), 0);
    check({tag, " PC_ex"}, 64'(PC_ex), 0);
    check({tag, " rdAddr_ex"}, 64'(rdAddr_ex), 0);
    check({tag, " rs1Data_ex"}, 64'(rs1Data_ex), 0);
    check({tag, " Imm_ex"}, 64'(Imm_ex), 0);
    check({tag, " ALUCode_ex"}, 64'(ALUCode_ex), 0);
    check({tag, " StallCount"}, 64'(StallCount), 0);
    check({tag, " Stall"}, 64'(Stall), 0);
  endtask

  // Load into EX writing register rd.
  task automatic issue_load(input logic [4:0] rd);
    @(negedge clk);
    set_idle();
    MemRead_id = 1; RegWrite_id = 1; MemtoReg_id = 1; rdAddr_id = rd; PC_id = 32'h100;
    predict_edge();
  endtask

  // Release reset at a falling edge; the following rising edge must capture normally.
  task automatic release_reset();
    @(negedge clk);
    check_outputs_zero("held_reset");
    rst_n = 1;
    model = '0;
    model_cnt = 0;
    set_random();
    Flush_ex = 0;
    predict_edge();
  endtask

  initial begin
    set_idle();
    model = '0;
    model_cnt = 0;
    rst_n = 0;
    #12;
    check_outputs_zero("reset");
    release_reset();

    // Back to a clean counter for the load-use scenario.
    @(negedge clk);
    rst_n = 0;
    #1;
    release_reset();

    // Load x5 then a reader of x5: one bubble, then the re-presented instruction is captured.
    issue_load(5'd5);
    @(negedge clk);
    set_idle();
    rs2Addr_id = 5; rs1Addr_id = 1; RegWrite_id = 1; rdAddr_id = 9; PC_id = 32'h104;
    Imm_id = 32'h55; rs2Data_id = 32'h1234;
    predict_edge();
    @(negedge clk);
    predict_edge();

    // Load to x0 never stalls.
    issue_load(5'd0);
    @(negedge clk);
    set_idle();
    rs1Addr_id = 0; RegWrite_id = 1; rdAddr_id = 3; PC_id = 32'h200; rs1Data_id = 32'hABCD;
    predict_edge();

    // Flush together with a hazard: flush wins, no count.
    issue_load(5'd6);
    @(negedge clk);
    set_idle();
    rs1Addr_id = 6; Flush_ex = 1; RegWrite_id = 1; rdAddr_id = 4; PC_id = 32'h300;
    predict_edge();

    // Write-back bypass on capture.
    @(negedge clk);
    set_idle();
    RegWrite_wb = 1; rdAddr_wb = 7; RegWriteData_wb = 32'hDEADBEEF;
    rs1Addr_id = 7; rs1Data_id = 32'h1; PC_id = 32'h400;
    predict_edge();
    @(posedge clk);
    #2;
`ifdef ID_EX_WB_BYPASS_EN
    check("bypass rs1Data_ex", 64'(rs1Data_ex), 64'h0000_0000_DEAD_BEEF);
`else
    check("no-bypass rs1Data_ex", 64'(rs1Data_ex), 64'h1);
`endif

    // Reset between edges while a load with RegWrite sits in EX and a hazard is pending.
    issue_load(5'd5);
    @(negedge clk);
    set_idle();
    rs1Addr_id = 5;
    #1;
    check("pre-reset Stall", 64'(Stall), 1);
    check("pre-reset RegWrite_ex", 64'(RegWrite_ex), 1);
    rst_n = 0;
    #1;
    check_outputs_zero("async_reset");
    release_reset();

    // Saturation: more than 2^W load-use pairs.
    for (int i = 0; i < 20; i++) begin
      issue_load(5'd5);
      @(negedge clk);
      set_idle();
      rs1Addr_id = 5;
      predict_edge();
    end
    @(posedge clk);
    #2;
    check("StallCount saturated", 64'(StallCount), 64'((1 << W) - 1));

    // Randomized traffic.
    @(negedge clk);
    rst_n = 0;
    #1;
    release_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      set_random();
      predict_edge();
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of stall event counter.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous reset, active low.
REQ-005 ALUCode_id in 4, ALUSrcA_id in 1, ALUSrcB_id in 2: decoded ALU controls.
REQ-006 RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id  in  1 each: decoded write-back and memory controls.
REQ-007 Imm_id, PC_id, rs1Data_id, rs2Data_id  in  32 each: ID-stage operands.
REQ-008 rs1Addr_id, rs2Addr_id, rdAddr_id  in  5 each: ID register addresses.
REQ-009 Flush_ex  in  1: taken branch or jump resolved in EX; squash the ID instruction.
REQ-010 RegWrite_wb in 1, rdAddr_wb in 5, RegWriteData_wb in 32: write-back port, used only by the bypass in REQ-028.
REQ-011 Outputs ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, rs1Addr_ex, rs2Addr_ex, rdAddr_ex: registered EX-stage copies, same widths as the _id inputs.
REQ-012 Stall  out  1: combinational; freezes the PC and the IF/ID register.
REQ-013 StallCount  out  STALL_CNT_W: count of load-use bubbles inserted.

Function
REQ-014 Hazard = MemRead_ex && rdAddr_ex!=0 && (rdAddr_ex==rs1Addr_id || rdAddr_ex==rs2Addr_id).
REQ-015 Stall SHALL equal Hazard && !Flush_ex, with no register in the path.
REQ-016 Normal cycle (no Hazard, no Flush_ex): every _ex output SHALL take its _id input at the next rising edge, giving 1-cycle latency.
REQ-017 Bubble: ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, rdAddr_ex, rs1Addr_ex, rs2Addr_ex, Imm_ex, rs1Data_ex, rs2Data_ex SHALL load 0; PC_ex SHALL load PC_id.
REQ-018 Flush_ex=1 SHALL load a bubble at the next edge, regardless of Hazard.
REQ-019 Hazard=1 with Flush_ex=0 SHALL load a bubble; the ID instruction is re-presented next cycle by the frozen upstream stage.
REQ-020 Flush_ex and Hazard together: flush priority, Stall=0, StallCount unchanged.
REQ-021 One load-use SHALL cost exactly one bubble: after the bubble MemRead_ex=0, so Hazard clears.
REQ-022 StallCount SHALL increment by 1 on each edge where Stall=1, and SHALL saturate at all-ones (no wrap).
REQ-023 rdAddr_ex=0 SHALL never cause Hazard, even when MemRead_ex=1.
REQ-024 A bubble SHALL never write registers or memory downstream; all of RegWrite_ex, MemRead_ex and MemWrite_ex are 0.

Reset
REQ-025 While rst_n=0, all _ex outputs and StallCount SHALL be 0 asynchronously (PC_ex=0); Stall is then 0 by REQ-014.
REQ-026 Reset deasserted mid-stream: the first edge after rst_n rises SHALL capture the _id inputs normally.
REQ-027 Reset asserted during a Hazard SHALL discard the pending bubble and clear StallCount immediately.

Configuration
REQ-028 With ID_EX_WB_BYPASS_EN defined: on capture, if RegWrite_wb && rdAddr_wb!=0 && rdAddr_wb==rs1Addr_id, rs1Data_ex SHALL load RegWriteData_wb instead of rs1Data_id; rs2 is handled identically. Bubbles still load 0.
REQ-029 Without ID_EX_WB_BYPASS_EN: rs1Data_ex/rs2Data_ex SHALL load rs1Data_id/rs2Data_id unchanged, and the wb inputs SHALL be unused.

Verification
REQ-030 Load x5 in EX (MemRead_ex=1, rdAddr_ex=5) with rs2Addr_id=5 -> Stall=1 same cycle; next edge RegWrite_ex=0, MemRead_ex=0, rdAddr_ex=0, StallCount=1; following edge captures the ID instruction.
REQ-031 MemRead_ex=1, rdAddr_ex=0, rs1Addr_id=0 -> Stall=0, normal capture.
REQ-032 Flush_ex=1 with Hazard=1 -> Stall=0, bubble loaded, StallCount unchanged.
REQ-033 Preload StallCount to all-ones via repeated hazards (STALL_CNT_W=4: 16 stalls) -> value stays 15.
REQ-034 Bypass build: RegWrite_wb=1, rdAddr_wb=7, RegWriteData_wb=0xDEADBEEF, rs1Addr_id=7, rs1Data_id=0x1 -> rs1Data_ex=0xDEADBEEF; non-bypass build -> 0x1.
REQ-035 rst_n pulled low between edges with RegWrite_ex=1 -> all outputs 0 before the next edge.
